bus16_mem_target: RTL and testbench
===================================

// Module: bus16_mem_target
// PURPOSE
//  Bus-side responder (target) for the 16-bit Minx16 system bus driven by the core BIU.
//  Decodes a word-aligned address window and serves reads and byte-lane writes from an internal RAM.
//  Inserts programmable wait states and answers each access with a one-cycle ready pulse.
//  Sits on the shared bus next to other targets; it drives data only while answering its own reads.
// PARAMETERS
//  A        16       address width (byte address)
//  D        16       data width; B = D/8 byte lanes
//  BASE     16'h8000 byte base address of the window; aligned to 2*2**AW
//  AW       8        log2 of the word count of the RAM (256 x 16)
//  WAIT     1        wait cycles between access capture and the ready pulse (0..15)
// PORTS
//  clk         in   1  clock
//  rst         in   1  reset, asynchronous, active-low
//  bus_Addr_i  in   A  byte address from the initiator
//  bus_Data_i  in   D  write data; byte writes are replicated on both lanes
//  bus_stb_i   in   B  byte-lane strobes, active-high; [1]=data[15:8], [0]=data[7:0]
//  bus_rd_i    in   1  read, active-low
//  bus_wr_i    in   1  write, active-low
//  bus_Data_o  out  D  read data
//  bus_Data_e  out  D  per-bit output enable, active-low (all 0 = drive)
//  bus_rdy_o   out  1  access complete, one-cycle pulse, active-high
// BEHAVIOUR
//  Reset: state IDLE; bus_Data_o=0; bus_Data_e=all 1; bus_rdy_o=0; wait counter=0. RAM contents are not reset.
//  Reset mid-access aborts it immediately; no rdy is issued; a pending write is dropped.
//  sel = (bus_Addr_i[A-1:AW+1] == BASE[A-1:AW+1]); word index = bus_Addr_i[AW:1]. Address bit 0 is ignored.
//  Access start: IDLE, sel=1, (rd_i==0 | wr_i==0), stb_i!=0. Capture addr, stb, data, dir; cnt<=WAIT.
//  Direction: wr_i==0 wins if rd_i and wr_i are both active (write).
//  stb_i==0 with rd/wr active, or sel=0: no access; stay IDLE; nothing is driven.
//  FSM (registered outputs):
//   IDLE -> WAIT when access starts and WAIT>0; IDLE -> RESP when access starts and WAIT==0.
//   WAIT: cnt decrements; when cnt==1 -> RESP.
//   RESP: rdy_o=1 for exactly this cycle. Write: lanes with captured stb=1 are updated.
//         Read: the full word is driven, data_e=0, and the initiator picks the lane. RESP -> IDLE always.
//  Latency: access seen at edge N; rdy_o high in cycle N+1+WAIT.
//   A read word is loaded into bus_Data_o on entry to RESP. data_e returns to all 1 on leaving RESP.
//  Back-to-back: an access present in the cycle after RESP is accepted from IDLE with no dead cycle.
//   This covers the initiator's unaligned second half (even addr, stb=2'b01).
//  Bus inputs are only sampled in IDLE; changes during WAIT/RESP are ignored.
//  Write then read of the same word returns the new data (write commits in RESP).
// CONFIGURATION
//  BUS16_TGT_ERR_EN defined: protocol violations complete with a fault instead of being ignored or resolved.
//   Adds output err_o (1 bit, sticky, reset 0).
//   Violation 1: rd_i and wr_i both active. Violation 2: stb_i==0 with rd/wr active in window.
//   On a violation, err_o<=1, the access runs the normal WAIT/RESP sequence with no RAM write,
//   and a read returns 16'hDEAD. err_o clears only on reset.
//  BUS16_TGT_ERR_EN undefined: no err_o port; violations behave as in BEHAVIOUR.
// STRUCTURE
//  Package bus16_pkg: RD/WR/STB/BUS active and enable polarity constants, A/D/B widths,
//   and target state encoding (IDLE=2'b00, WAIT=2'b01, RESP=2'b10).
//  Sub-module bus16_tgt_ram: two 8-bit x 2**AW banks with per-lane write enable and a synchronous read.
//  The FSM, decode and wait counter live in this module.
// TESTING
//  1 Aligned word write 0x8010<=0x1234 (stb=11, wr=0) then read -> rdy 2 cycles after capture; data 0x1234; data_e=0 only in RESP.
//  2 Byte write 0x8011<=0xAB (data 0xABAB, stb=10) after test 1, then word read -> 0xAB34; low lane untouched.
//  3 Unaligned pair: rdy pulse, then immediately a new access at 0x8012 with stb=01 -> accepted next cycle; second rdy after WAIT+1.
//  4 Access at 0x4000 or with stb=00 -> no rdy for 20 cycles; data_e stays all 1.
//  5 Assert rst during WAIT of a write to 0x8020 -> rdy never pulses; a later read of 0x8020 returns the prior content.
//  6 With BUS16_TGT_ERR_EN, set rd=0 and wr=0 at 0x8000 -> rdy pulses, read data 0xDEAD, err_o=1 until reset, RAM unchanged. Re-run with WAIT=0.

Source files
------------

// File: rtl/bus16_pkg.sv
// Shared constants for the Minx16 system bus: signal polarities, bus widths
// and the encoding of the memory target's state machine.
package bus16_pkg;

    localparam int BUS_A = 16;
    localparam int BUS_D = 16;
    localparam int BUS_B = BUS_D / 8;

    localparam logic RD_ACTIVE  = 1'b0;
    localparam logic WR_ACTIVE  = 1'b0;
    localparam logic STB_ACTIVE = 1'b1;
    localparam logic RDY_ACTIVE = 1'b1;
    localparam logic OE_DRIVE   = 1'b0;
    localparam logic RST_ACTIVE = 1'b0;

    localparam logic [15:0] ERR_READ_DATA = 16'hDEAD;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } tgt_state_e;

endpackage

// File: rtl/bus16_tgt_ram.sv
// Byte-laned word RAM for the bus16 memory target: one 8-bit bank per lane,
// per-lane write enable and a registered (synchronous) read port.
module bus16_tgt_ram
    import bus16_pkg::*;
#(
    parameter int AW = 8,
    parameter int B  = BUS_B
) (
    input  logic            clk,
    input  logic [B-1:0]    i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [8*B-1:0]  i_wdata,
    input  logic [AW-1:0]   i_raddr,
    output logic [8*B-1:0]  o_rdata
);

    generate
        for (genvar gi = 0; gi < B; gi++) begin : g_lane
            logic [7:0] r_mem [2**AW];
            logic [7:0] r_q;

            always_ff @(posedge clk) begin
                if (i_we[gi]) begin
                    r_mem[i_waddr] <= i_wdata[8*gi +: 8];
                end
                r_q <= r_mem[i_raddr];
            end

            assign o_rdata[8*gi +: 8] = r_q;
        end
    endgenerate

endmodule

// File: rtl/bus16_mem_target.sv
// Minx16 bus memory target: window decode, programmable wait states, one-cycle
// ready pulse. Define BUS16_TGT_ERR_EN to fault protocol violations via err_o.
module bus16_mem_target
    import bus16_pkg::*;
#(
    parameter int           A    = BUS_A,
    parameter int           D    = BUS_D,
    parameter logic [A-1:0] BASE = 16'h8000,
    parameter int           AW   = 8,
    parameter int           WAIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [A-1:0]     bus_Addr_i,
    input  logic [D-1:0]     bus_Data_i,
    input  logic [D/8-1:0]   bus_stb_i,
    input  logic             bus_rd_i,
    input  logic             bus_wr_i,
    output logic [D-1:0]     bus_Data_o,
    output logic [D-1:0]     bus_Data_e,
    output logic             bus_rdy_o
`ifdef BUS16_TGT_ERR_EN
    ,
    output logic             err_o
`endif
);

    localparam int B  = D / 8;
    localparam int CW = 4;

    tgt_state_e     r_state;
    tgt_state_e     w_state_next;
    logic [CW-1:0]  r_cnt;
    logic [AW-1:0]  r_addr;
    logic [B-1:0]   r_stb;
    logic [D-1:0]   r_data;
    logic           r_is_wr;
    logic           r_fault;
    logic           r_rdy;
    logic           r_drive;

    logic           w_sel;
    logic           w_rd;
    logic           w_wr;
    logic [B-1:0]   w_stb;
    logic           w_start;
    logic           w_start_wr;
    logic           w_viol;
    logic           w_load;
    logic           w_next_is_wr;
    logic [B-1:0]   w_we;
    logic [AW-1:0]  w_raddr;
    logic [D-1:0]   w_ram_rdata;
    logic [D-1:0]   w_rdata_sel;
    logic           w_unused_addr0;

    assign w_sel          = (bus_Addr_i[A-1:AW+1] == BASE[A-1:AW+1]);
    assign w_rd           = (bus_rd_i == RD_ACTIVE);
    assign w_wr           = (bus_wr_i == WR_ACTIVE);
    assign w_stb          = STB_ACTIVE ? bus_stb_i : ~bus_stb_i;
    assign w_unused_addr0 = bus_Addr_i[0];

`ifdef BUS16_TGT_ERR_EN
    // Violating requests still complete; a doubled rd/wr is answered as a faulted read.
    assign w_viol     = w_sel & ((w_rd & w_wr) | ((w_rd | w_wr) & ~(|w_stb)));
    assign w_start    = w_sel & (w_rd | w_wr);
    assign w_start_wr = w_wr & ~w_rd;
`else
    assign w_viol     = 1'b0;
    assign w_start    = w_sel & (w_rd | w_wr) & (|w_stb);
    assign w_start_wr = w_wr;
`endif

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_load       = 1'b1;
                    w_state_next = (WAIT == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == CW'(1)) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_next_is_wr = w_load ? w_start_wr : r_is_wr;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_stb   <= '0;
            r_data  <= '0;
            r_is_wr <= 1'b0;
            r_fault <= 1'b0;
            r_rdy   <= ~RDY_ACTIVE;
            r_drive <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_rdy   <= (w_state_next == ST_RESP) ? RDY_ACTIVE : ~RDY_ACTIVE;
            r_drive <= (w_state_next == ST_RESP) & ~w_next_is_wr;
            if (w_load) begin
                r_addr  <= bus_Addr_i[AW:1];
                r_stb   <= w_stb;
                r_data  <= bus_Data_i;
                r_is_wr <= w_start_wr;
                r_fault <= w_viol;
                r_cnt   <= CW'(WAIT);
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

`ifdef BUS16_TGT_ERR_EN
    logic r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            r_err <= 1'b0;
        end else if (w_load & w_viol) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`endif

    // The RAM follows the live bus while idle so a zero-wait read has its data on entry to RESP.
    assign w_raddr = (r_state == ST_IDLE) ? bus_Addr_i[AW:1] : r_addr;
    assign w_we    = ((r_state == ST_RESP) && r_is_wr && !r_fault) ? r_stb : '0;

    bus16_tgt_ram #(
        .AW (AW),
        .B  (B)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_addr),
        .i_wdata (r_data),
        .i_raddr (w_raddr),
        .o_rdata (w_ram_rdata)
    );

    assign w_rdata_sel = r_fault ? D'(ERR_READ_DATA) : w_ram_rdata;
    assign bus_Data_o  = r_drive ? w_rdata_sel : '0;
    assign bus_Data_e  = r_drive ? {D{OE_DRIVE}} : {D{~OE_DRIVE}};
    assign bus_rdy_o   = r_rdy;

endmodule

// File: tb/tb_bus16_mem_target.sv
// Directed bench for bus16_mem_target: one instance with WAIT=1, one with WAIT=0;
// read data is checked through a scoreboard queue filled when each read is issued.
module tb_bus16_mem_target;

    typedef struct {
        logic [15:0] data;
        string       tag;
    } exp_t;

    localparam int WAITS [2] = '{0, 1};

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr   [2];
    logic [15:0] wdat   [2];
    logic [1:0]  stb_s  [2];
    logic        rd     [2];
    logic        wr     [2];
    logic [15:0] data_o [2];
    logic [15:0] data_e [2];
    logic        rdy    [2];
`ifdef BUS16_TGT_ERR_EN
    logic        err    [2];
`endif

    exp_t sb_q [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    bus16_mem_target #(.WAIT(0)) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .bus_Addr_i (addr[0]),
        .bus_Data_i (wdat[0]),
        .bus_stb_i  (stb_s[0]),
        .bus_rd_i   (rd[0]),
        .bus_wr_i   (wr[0]),
        .bus_Data_o (data_o[0]),
        .bus_Data_e (data_e[0]),
        .bus_rdy_o  (rdy[0])
`ifdef BUS16_TGT_ERR_EN
        ,
        .err_o      (err[0])
`endif
    );

    bus16_mem_target #(.WAIT(1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .bus_Addr_i (addr[1]),
        .bus_Data_i (wdat[1]),
        .bus_stb_i  (stb_s[1]),
        .bus_rd_i   (rd[1]),
        .bus_wr_i   (wr[1]),
        .bus_Data_o (data_o[1]),
        .bus_Data_e (data_e[1]),
        .bus_rdy_o  (rdy[1])
`ifdef BUS16_TGT_ERR_EN
        ,
        .err_o      (err[1])
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_release(input int k);
        rd[k]    = 1'b1;
        wr[k]    = 1'b1;
        stb_s[k] = 2'b00;
        addr[k]  = 16'h0000;
        wdat[k]  = 16'(($urandom));
    endtask

    // One access: drive for one edge, then count cycles to the ready pulse.
    task automatic access(input int k, input string tag, input logic [15:0] a,
                          input logic [15:0] d, input logic [1:0] stb,
                          input logic rd_n, input logic wr_n,
                          input logic exp_read, input logic [15:0] exp_d);
        int   lat;
        bit   seen;
        bit   e_ok;
        exp_t e;
        @(negedge clk);
        check({tag, " idle_rdy"}, 32'(rdy[k]), 32'd0);
        check({tag, " idle_oe"}, 32'(data_e[k]), 32'h0000ffff);
        addr[k]  = a;
        wdat[k]  = d;
        stb_s[k] = stb;
        rd[k]    = rd_n;
        wr[k]    = wr_n;
        if (exp_read) sb_q.push_back('{exp_d, tag});
        @(posedge clk);
        #1;
        bus_release(k);
        lat  = 0;
        seen = 1'b0;
        e_ok = 1'b1;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (rdy[k]) seen = 1'b1;
            else if (data_e[k] !== 16'hffff) e_ok = 1'b0;
        end
        check({tag, " rdy_latency"}, seen ? 32'(lat) : 32'd99, 32'(WAITS[k] + 1));
        check({tag, " oe_before_rdy"}, 32'(e_ok), 32'd1);
        if (exp_read) begin
            e = sb_q.pop_front();
            if (seen) begin
                check({e.tag, " rdata"}, 32'(data_o[k]), 32'(e.data));
                check({e.tag, " oe_resp"}, 32'(data_e[k]), 32'h00000000);
            end
        end else if (seen) begin
            check({tag, " oe_wr_resp"}, 32'(data_e[k]), 32'h0000ffff);
        end
    endtask

    // A request that must be ignored: hold it for 20 cycles and watch for any response.
    task automatic no_access(input int k, input string tag, input logic [15:0] a,
                             input logic [1:0] stb, input logic rd_n, input logic wr_n);
        int n_rdy;
        int n_oe;
        @(negedge clk);
        addr[k]  = a;
        wdat[k]  = 16'h5a5a;
        stb_s[k] = stb;
        rd[k]    = rd_n;
        wr[k]    = wr_n;
        n_rdy = 0;
        n_oe  = 0;
        repeat (20) begin
            @(negedge clk);
            if (rdy[k] !== 1'b0) n_rdy++;
            if (data_e[k] !== 16'hffff) n_oe++;
        end
        bus_release(k);
        check({tag, " rdy_count"}, 32'(n_rdy), 32'd0);
        check({tag, " oe_count"}, 32'(n_oe), 32'd0);
    endtask

    initial begin
        int n_rdy;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) bus_release(k);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset%0d rdy", k), 32'(rdy[k]), 32'd0);
            check($sformatf("reset%0d dout", k), 32'(data_o[k]), 32'd0);
            check($sformatf("reset%0d oe", k), 32'(data_e[k]), 32'h0000ffff);
`ifdef BUS16_TGT_ERR_EN
            check($sformatf("reset%0d err", k), 32'(err[k]), 32'd0);
`endif
        end
        rst = 1'b1;

        // Word write/read, byte-lane write, address bit 0 ignored
        access(1, "t1_wr", 16'h8010, 16'h1234, 2'b11, 1'b1, 1'b0, 1'b0, 16'h0);
        access(1, "t1_rd", 16'h8010, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b1, 16'h1234);
        access(1, "t2_wr", 16'h8011, 16'hABAB, 2'b10, 1'b1, 1'b0, 1'b0, 16'h0);
        access(1, "t2_rd", 16'h8010, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b1, 16'hAB34);
        access(1, "t2_rd_odd", 16'h8011, 16'h0000, 2'b10, 1'b0, 1'b1, 1'b1, 16'hAB34);

        // Unaligned pair issued back-to-back
        access(1, "t3_pre", 16'h8012, 16'h1200, 2'b11, 1'b1, 1'b0, 1'b0, 16'h0);
        access(1, "t3_hi", 16'h8011, 16'h7777, 2'b10, 1'b1, 1'b0, 1'b0, 16'h0);
        access(1, "t3_lo", 16'h8012, 16'h8888, 2'b01, 1'b1, 1'b0, 1'b0, 16'h0);
        access(1, "t3_rd_a", 16'h8010, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b1, 16'h7734);
        access(1, "t3_rd_b", 16'h8012, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b1, 16'h1288);

        // Requests outside the window or without strobes
        no_access(1, "t4_low", 16'h4000, 2'b11, 1'b0, 1'b1);
        no_access(1, "t4_above", 16'h8200, 2'b11, 1'b1, 1'b0);
`ifndef BUS16_TGT_ERR_EN
        no_access(1, "t4_stb0", 16'h8010, 2'b00, 1'b0, 1'b1);
        access(1, "both_wr", 16'h8030, 16'h5A5A, 2'b11, 1'b0, 1'b0, 1'b0, 16'h0);
        access(1, "both_rd", 16'h8030, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b1, 16'h5A5A);
`else
        access(1, "t6_pre", 16'h8000, 16'h0F0F, 2'b11, 1'b1, 1'b0, 1'b0, 16'h0);
        check("t6 err_before", 32'(err[1]), 32'd0);
        access(1, "t6_viol", 16'h8000, 16'hFFFF, 2'b11, 1'b0, 1'b0, 1'b1, 16'hDEAD);
        check("t6 err_set", 32'(err[1]), 32'd1);
        access(1, "t6_stb0", 16'h8000, 16'h1111, 2'b00, 1'b1, 1'b0, 1'b0, 16'h0);
        access(1, "t6_rd", 16'h8000, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b1, 16'h0F0F);
        check("t6 err_sticky", 32'(err[1]), 32'd1);
`endif

        // Reset during the wait state of a write
        access(1, "t5_pre", 16'h8020, 16'h1111, 2'b11, 1'b1, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        addr[1]  = 16'h8020;
        wdat[1]  = 16'h9999;
        stb_s[1] = 2'b11;
        wr[1]    = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus_release(1);
        #1;
        check("t5 rst_oe", 32'(data_e[1]), 32'h0000ffff);
        n_rdy = 0;
        repeat (3) begin
            @(negedge clk);
            if (rdy[1] !== 1'b0) n_rdy++;
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (rdy[1] !== 1'b0) n_rdy++;
        end
        check("t5 no_rdy", 32'(n_rdy), 32'd0);
`ifdef BUS16_TGT_ERR_EN
        check("t5 err_cleared", 32'(err[1]), 32'd0);
`endif
        access(1, "t5_rd", 16'h8020, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b1, 16'h1111);

        // Zero-wait instance: last word of the window, byte lanes, back-to-back
        access(0, "w0_wr", 16'h81FE, 16'hC3C3, 2'b11, 1'b1, 1'b0, 1'b0, 16'h0);
        access(0, "w0_rd", 16'h81FF, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b1, 16'hC3C3);
        access(0, "w0_b1", 16'h8100, 16'hBEEF, 2'b11, 1'b1, 1'b0, 1'b0, 16'h0);
        access(0, "w0_b2", 16'h8100, 16'h4242, 2'b01, 1'b1, 1'b0, 1'b0, 16'h0);
        access(0, "w0_rd2", 16'h8100, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b1, 16'hBE42);
        no_access(0, "w0_out", 16'h0100, 2'b11, 1'b0, 1'b1);
`ifdef BUS16_TGT_ERR_EN
        access(0, "w0_viol", 16'h8000, 16'h0000, 2'b11, 1'b0, 1'b0, 1'b1, 16'hDEAD);
        check("w0 err_set", 32'(err[0]), 32'd1);
        access(0, "w0_rd3", 16'h8100, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b1, 16'hBE42);
`endif

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
